// File: rtl/uart_rx_word_assembler.sv
// 8N1 UART receiver packing four bytes (first byte in [31:24]) into a 32-bit word.
// Optional idle flush of partial words: define RX_TIMEOUT_EN.
module uart_rx_word_assembler #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        frame_err_o,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS == 0) begin : g_bad_cfg
    $error("uart_rx_word_assembler: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS > 0");
  end

  logic          rx_meta_q, rx_s_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [23:0]   word_q, word_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          to_q, to_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed
          state_d = S_IDLE;
          cnt_d   = '0;
          if (rx_s_q) begin
            word_d     = {word_q[15:0], shift_q};
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              data_d  = {word_q, shift_q};
              valid_d = 1'b1;
            end
          end else begin
            ferr_d     = 1'b1;
            byte_cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef RX_TIMEOUT_EN
  always_comb begin
    idle_d = '0;
    to_d   = 1'b0;
    if (state_q == S_IDLE && byte_cnt_q != 2'd0 && rx_s_q) begin
      if (idle_q == TO_LAST) begin
        to_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
`ifdef RX_TIMEOUT_EN
      byte_cnt_q <= to_d ? 2'd0 : byte_cnt_d;
`else
      byte_cnt_q <= byte_cnt_d;
`endif
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench for uart_rx_word_assembler at CLKS_PER_BIT=8; line driven on negedge.
module tb_uart_rx_word_assembler;
  localparam int unsigned CPB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_i;
  logic [31:0] data_o;
  logic        valid_o, frame_err_o, timeout_o, busy_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned valid_cnt = 0, ferr_cnt = 0, to_cnt = 0, overlap_cnt = 0;
  logic [31:0] words[$];

  uart_rx_word_assembler #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .frame_err_o(frame_err_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid_o) begin
        valid_cnt++;
        words.push_back(data_o);
      end
      if (frame_err_o) ferr_cnt++;
      if (timeout_o) to_cnt++;
      if (valid_o && frame_err_o) overlap_cnt++;
    end
  end

  typedef struct {
    logic [7:0]  b [4];
    int unsigned gap;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      rx_i = v;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned gap_bits);
    hold(1'b0, CPB);
    for (int unsigned i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
    hold(1'b1, gap_bits * CPB);
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3, input int unsigned gap);
    send_byte(b0, 1'b1, gap);
    send_byte(b1, 1'b1, gap);
    send_byte(b2, 1'b1, gap);
    send_byte(b3, 1'b1, gap);
    hold(1'b1, 2 * CPB);
  endtask

  vec_t vecs [3];
  int unsigned v0;

  initial begin
    vecs[0] = '{b: '{8'h12, 8'h34, 8'h56, 8'h78}, gap: 2, exp: 32'h12345678};
    vecs[1] = '{b: '{8'hA5, 8'h5A, 8'hFF, 8'h00}, gap: 0, exp: 32'hA55AFF00};
    vecs[2] = '{b: '{8'h80, 8'h01, 8'h7F, 8'hFE}, gap: 1, exp: 32'h80017FFE};

    rx_i  = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data_o", data_o, 32'h0);
    check("reset valid_o", {31'b0, valid_o}, 32'h0);
    check("reset frame_err_o", {31'b0, frame_err_o}, 32'h0);
    check("reset timeout_o", {31'b0, timeout_o}, 32'h0);
    check("reset busy_o", {31'b0, busy_o}, 32'h0);
    reset = 1'b0;
    hold(1'b1, 2 * CPB);

    for (int unsigned i = 0; i < 3; i++) begin
      v0 = valid_cnt;
      send_word(vecs[i].b[0], vecs[i].b[1], vecs[i].b[2], vecs[i].b[3], vecs[i].gap);
      check($sformatf("vec%0d valid pulses", i), valid_cnt - v0, 1);
      check($sformatf("vec%0d data_o", i), data_o, vecs[i].exp);
      check($sformatf("vec%0d frame_err", i), ferr_cnt, 0);
    end

    // Glitch shorter than half a bit
    v0 = valid_cnt;
    hold(1'b0, 3);
    hold(1'b1, 2 * CPB);
    check("glitch busy_o", {31'b0, busy_o}, 32'h0);
    check("glitch valid", valid_cnt - v0, 0);
    check("glitch frame_err", ferr_cnt, 0);
    send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD, 2);
    check("after glitch data_o", data_o, 32'hAABBCCDD);
    check("after glitch valid", valid_cnt - v0, 1);

    // Framing error drops the partial word
    v0 = valid_cnt;
    send_byte(8'h01, 1'b1, 2);
    send_byte(8'h02, 1'b0, 2);
    check("frame_err pulses", ferr_cnt, 1);
    send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD, 2);
    check("after ferr valid", valid_cnt - v0, 1);
    check("after ferr data_o", data_o, 32'hAABBCCDD);

    // Eight bytes back-to-back
    v0 = valid_cnt;
    for (int unsigned i = 0; i < 8; i++) send_byte(8'(i), 1'b1, 0);
    hold(1'b1, 2 * CPB);
    check("b2b valid pulses", valid_cnt - v0, 2);
    check("b2b word0", words[words.size() - 2], 32'h00010203);
    check("b2b word1", words[words.size() - 1], 32'h04050607);

    // Reset in the middle of the third byte
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    hold(1'b0, CPB);
    hold(1'b1, 3 * CPB);
    reset = 1'b1;
    rx_i  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midreset data_o", data_o, 32'h0);
    check("midreset valid_o", {31'b0, valid_o}, 32'h0);
    check("midreset frame_err_o", {31'b0, frame_err_o}, 32'h0);
    check("midreset busy_o", {31'b0, busy_o}, 32'h0);
    reset = 1'b0;
    hold(1'b1, 2 * CPB);
    v0 = valid_cnt;
    send_word(8'h55, 8'h66, 8'h77, 8'h88, 2);
    check("after reset valid", valid_cnt - v0, 1);
    check("after reset data_o", data_o, 32'h55667788);

`ifdef RX_TIMEOUT_EN
    v0 = valid_cnt;
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 25);
    check("timeout pulses", to_cnt, 1);
    check("timeout no valid", valid_cnt - v0, 0);
    send_word(8'hDE, 8'hAD, 8'hBE, 8'hEF, 2);
    check("after timeout data_o", data_o, 32'hDEADBEEF);
    check("after timeout valid", valid_cnt - v0, 1);
`else
    check("timeout_o stays low", to_cnt, 0);
`endif

    check("valid/ferr overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks done %0d", checks);
    $fatal(1);
  end
endmodule
